// File: rtl/sum_frame_serializer_if.sv
// Sample handshake and serial-output bundle between the adder side and the frame serializer.
// The serializer takes the slave view and the upstream/observer side takes the master view.
interface sum_frame_serializer_if #(
  parameter int SAMPLE_W = 5
);
  logic [SAMPLE_W-1:0] sum_i;
  logic                sum_valid_i;
  logic                sum_ready_o;
  logic                ser_o;
  logic                ser_frame_o;
  logic                frame_done_o;
  logic                overflow_o;

  modport master (
    output sum_i, sum_valid_i,
    input  sum_ready_o, ser_o, ser_frame_o, frame_done_o, overflow_o
  );

  modport slave (
    input  sum_i, sum_valid_i,
    output sum_ready_o, ser_o, ser_frame_o, frame_done_o, overflow_o
  );
endinterface

// File: rtl/sum_frame_serializer.sv
// Sums FRAME_LEN adder samples into a saturating total and shifts it out MSB-first
// as {start=1, total, even parity} on a single serial pin.
module sum_frame_serializer #(
  parameter int SAMPLE_W  = 5,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sum_frame_serializer_if.slave bus
);

  localparam int CNT_W   = $clog2(FRAME_LEN + 1);
  localparam int BIT_W   = $clog2(ACC_W + 3);
  localparam int SUM_W   = ((ACC_W > SAMPLE_W) ? ACC_W : SAMPLE_W) + 1;
  localparam int SHIFT_W = ACC_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(ACC_W + 1);
  localparam logic [BIT_W-1:0] BIT_PREV  = BIT_W'(ACC_W);
  localparam logic [SUM_W-1:0] SUM_MAX   = SUM_W'((1 << ACC_W) - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  function automatic logic f_even_parity(input logic [ACC_W-1:0] i_data);
    return ^i_data;
  endfunction

  state_t             r_state,     w_state_nxt;
  logic [ACC_W-1:0]   r_acc,       w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [BIT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
  logic [SHIFT_W-1:0] r_shift,     w_shift_nxt;
  logic               r_ready,     w_ready_nxt;
  logic               r_frame,     w_frame_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_ovf,       w_ovf_nxt;

  logic [SUM_W-1:0]   w_sum;
  logic               w_sat;
  logic [ACC_W-1:0]   w_acc_final;

  // The wide adder makes any carry past ACC_W visible so the total can clamp.
  assign w_sum       = SUM_W'(r_acc) + SUM_W'(bus.sum_i);
  assign w_sat       = (w_sum > SUM_MAX);
  assign w_acc_final = w_sat ? ACC_MAX : w_sum[ACC_W-1:0];

  // Next-state and next-output logic for the accumulate/send FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ready_nxt   = r_ready;
    w_frame_nxt   = r_frame;
    w_done_nxt    = 1'b0;
    w_ovf_nxt     = r_ovf;
    case (r_state)
      ST_ACCUM: begin
        if (bus.sum_valid_i && r_ready) begin
          w_ovf_nxt = r_ovf | w_sat;
          if (r_cnt == CNT_LAST) begin
            w_shift_nxt   = {1'b1, w_acc_final, f_even_parity(w_acc_final)};
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_SEND;
            w_ready_nxt   = 1'b0;
            w_frame_nxt   = 1'b1;
          end else begin
            w_acc_nxt = w_acc_final;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      ST_SEND: begin
        // Zero fill leaves the register clear, so ser_o idles low after the parity bit.
        w_shift_nxt = {r_shift[SHIFT_W-2:0], 1'b0};
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt   = ST_ACCUM;
          w_bit_cnt_nxt = '0;
          w_ready_nxt   = 1'b1;
          w_frame_nxt   = 1'b0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          w_done_nxt    = (r_bit_cnt == BIT_PREV);
        end
      end
      default: begin
        w_state_nxt   = ST_ACCUM;
        w_bit_cnt_nxt = '0;
        w_shift_nxt   = '0;
        w_ready_nxt   = 1'b1;
        w_frame_nxt   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; rst drops any partial total or frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ready   <= w_ready_nxt;
      r_frame   <= w_frame_nxt;
      r_done    <= w_done_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign bus.sum_ready_o  = r_ready;
  assign bus.ser_o        = r_shift[SHIFT_W-1];
  assign bus.ser_frame_o  = r_frame;
  assign bus.frame_done_o = r_done;
  assign bus.overflow_o   = r_ovf;

endmodule
